fp_round_pack: RTL and testbench

//  Downstream stage of the floating-point converter: accepts the raw {sign, exponent,

---
 rtl/fp_round_pack.sv | 121 ++++++++++++
 tb/tb_fp_round_pack.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round_pack.sv
// Rounding, renormalisation and packing stage of the FP converter.
// Two-stage elastic valid/ready pipeline producing the 8-bit {sign, exp, sig} byte.
module fp_round_pack #(
    parameter int SAT_W    = 8,
    parameter bit ROUND_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic             sign,
    input  logic [2:0]       exponent,
    input  logic [3:0]       significand,
    input  logic             fifthBit,
    output logic             outValid,
    input  logic             outReady,
    output logic [7:0]       fpOut,
    output logic [SAT_W-1:0] satCount,
    input  logic             clearSat
);

    logic             s1_valid_q, s1_valid_d;
    logic             s1_sign_q, s1_sign_d;
    logic [2:0]       s1_exp_q, s1_exp_d;
    logic [4:0]       s1_sum_q, s1_sum_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       fp_out_q, fp_out_d;
    logic             sat_flag_q, sat_flag_d;
    logic [SAT_W-1:0] sat_count_q, sat_count_d;

    logic       s2_adv, s1_adv, in_fire, out_fire, round_inc;
    logic [7:0] packed_byte;
    logic       packed_sat;

    // Ready is derived only from registered occupancy and outReady.
    assign s2_adv    = !out_valid_q || outReady;
    assign s1_adv    = !s1_valid_q || s2_adv;
    assign in_fire   = inValid && s1_adv;
    assign out_fire  = out_valid_q && outReady;
    assign round_inc = ROUND_EN ? fifthBit : 1'b0;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_exp_d   = s1_exp_q;
        s1_sum_d   = s1_sum_q;
        if (s1_adv) begin
            s1_valid_d = inValid;
        end
        if (in_fire) begin
            s1_sign_d = sign;
            s1_exp_d  = exponent;
            s1_sum_d  = {1'b0, significand} + {4'b0000, round_inc};
        end
    end

    // A carry out of the significand bumps the exponent; at exponent 7 it saturates.
    always_comb begin
        packed_byte = {s1_sign_q, s1_exp_q, s1_sum_q[3:0]};
        packed_sat  = 1'b0;
        if (s1_sum_q[4]) begin
            if (s1_exp_q != 3'd7) begin
                packed_byte = {s1_sign_q, s1_exp_q + 3'd1, 4'b1000};
            end else begin
                packed_byte = {s1_sign_q, 3'd7, 4'b1111};
                packed_sat  = 1'b1;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        fp_out_d    = fp_out_q;
        sat_flag_d  = sat_flag_q;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                fp_out_d   = packed_byte;
                sat_flag_d = packed_sat;
            end
        end
    end

    // Counter sticks at all-ones; clear takes priority over a same-cycle event.
    always_comb begin
        sat_count_d = sat_count_q;
        if (clearSat) begin
            sat_count_d = '0;
        end else if (out_fire && sat_flag_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + SAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= 3'd0;
            s1_sum_q    <= 5'd0;
            out_valid_q <= 1'b0;
            fp_out_q    <= 8'h00;
            sat_flag_q  <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_sum_q    <= s1_sum_d;
            out_valid_q <= out_valid_d;
            fp_out_q    <= fp_out_d;
            sat_flag_q  <= sat_flag_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign inReady  = s1_adv;
    assign outValid = out_valid_q;
    assign fpOut    = fp_out_q;
    assign satCount = sat_count_q;

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed scoreboard bench for fp_round_pack: a rounding instance and a truncating one.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_fp_round_pack;

    logic       clk = 1'b0;
    logic       rst;
    logic       inValid, inReady, sign, fifthBit, outValid, outReady, clearSat;
    logic [2:0] exponent;
    logic [3:0] significand;
    logic [7:0] fpOut, satCount;

    logic       tr_in_valid, tr_in_ready, tr_sign, tr_fifth, tr_out_valid, tr_out_ready, tr_clear;
    logic [2:0] tr_exp;
    logic [3:0] tr_sig;
    logic [7:0] tr_fp_out, tr_sat_count;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    bit         lat_chk = 1'b0;
    logic [7:0] exp_q[$];
    int         cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_round_pack #(.SAT_W(8), .ROUND_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .sign(sign),
        .exponent(exponent), .significand(significand), .fifthBit(fifthBit),
        .outValid(outValid), .outReady(outReady), .fpOut(fpOut),
        .satCount(satCount), .clearSat(clearSat)
    );

    fp_round_pack #(.SAT_W(8), .ROUND_EN(1'b0)) dut_tr (
        .clk(clk), .rst(rst), .inValid(tr_in_valid), .inReady(tr_in_ready), .sign(tr_sign),
        .exponent(tr_exp), .significand(tr_sig), .fifthBit(tr_fifth),
        .outValid(tr_out_valid), .outReady(tr_out_ready), .fpOut(tr_fp_out),
        .satCount(tr_sat_count), .clearSat(tr_clear)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at a drive point; returns at the drive point after the accepting edge.
    task automatic applyStimulus(input logic s, input logic [2:0] e, input logic [3:0] sg,
                                 input logic f, input logic [7:0] expv);
        logic rdy;
        int   acc_cyc;
        inValid     = 1'b1;
        sign        = s;
        exponent    = e;
        significand = sg;
        fifthBit    = f;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy     = inReady;
            acc_cyc = cyc;
            tick();
            if (rdy) begin
                exp_q.push_back(expv);
                cyc_q.push_back(acc_cyc);
                return;
            end
        end
        checks++;
        errors++;
        $error("[TB] FAIL accept_timeout observed inReady=0 expected inReady=1");
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0 && !outValid) return;
            tick();
        end
        checks++;
        errors++;
        $error("[TB] FAIL drain_timeout observed %0d pending expected 0", exp_q.size());
    endtask

    // Scoreboard: every output transfer must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && outValid && outReady) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL spurious_out observed %0h expected none", fpOut);
            end else begin
                logic [7:0] e;
                int         c;
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                checkOutput("fpOut", fpOut, e);
                if (lat_chk) checkOutput("latency", cyc - c, 2);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog observed no finish expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1; inValid = 1'b0; sign = 1'b0; exponent = 3'd0; significand = 4'd0;
        fifthBit = 1'b0; outReady = 1'b0; clearSat = 1'b0;
        tr_in_valid = 1'b0; tr_sign = 1'b0; tr_exp = 3'd0; tr_sig = 4'd0; tr_fifth = 1'b0;
        tr_out_ready = 1'b1; tr_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        checkOutput("reset_outValid", outValid, 0);
        checkOutput("reset_fpOut", fpOut, 8'h00);
        checkOutput("reset_inReady", inReady, 1);
        checkOutput("reset_satCount", satCount, 0);
        tick();

        $display("[TB] back-to-back rounding");
        outReady = 1'b1;
        lat_chk  = 1'b1;
        applyStimulus(1'b0, 3'd3, 4'b1010, 1'b1, 8'h3B);
        applyStimulus(1'b1, 3'd2, 4'b1100, 1'b0, 8'hAC);
        inValid = 1'b0;
        waitDrain();

        $display("[TB] renormalise and saturate");
        applyStimulus(1'b0, 3'd4, 4'b1111, 1'b1, 8'h58);
        applyStimulus(1'b1, 3'd7, 4'b1111, 1'b1, 8'hFF);
        inValid = 1'b0;
        waitDrain();
        @(negedge clk);
        checkOutput("satCount_one", satCount, 1);
        tick();

        $display("[TB] stall with full pipe");
        lat_chk  = 1'b0;
        outReady = 1'b0;
        applyStimulus(1'b0, 3'd1, 4'b1000, 1'b0, 8'h18);
        applyStimulus(1'b1, 3'd5, 4'b1001, 1'b1, 8'hDA);
        sign = 1'b0; exponent = 3'd6; significand = 4'b0111; fifthBit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_inReady", inReady, 0);
            checkOutput("stall_outValid", outValid, 1);
            checkOutput("stall_fpOut", fpOut, 8'h18);
            tick();
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        applyStimulus(1'b0, 3'd6, 4'b0111, 1'b1, 8'h68);
        inValid = 1'b0;
        waitDrain();

        $display("[TB] truncating instance");
        tr_in_valid = 1'b1; tr_sign = 1'b0; tr_exp = 3'd7; tr_sig = 4'b1111; tr_fifth = 1'b1;
        @(negedge clk);
        checkOutput("tr_inReady", tr_in_ready, 1);
        tick();
        tr_in_valid = 1'b0;
        tick();
        @(negedge clk);
        checkOutput("tr_outValid", tr_out_valid, 1);
        checkOutput("tr_fpOut", tr_fp_out, 8'h7F);
        tick();
        @(negedge clk);
        checkOutput("tr_satCount", tr_sat_count, 0);
        tick();

        $display("[TB] saturation counter ceiling");
        lat_chk = 1'b1;
        for (int i = 0; i < 260; i++) applyStimulus(1'b1, 3'd7, 4'b1111, 1'b1, 8'hFF);
        inValid = 1'b0;
        waitDrain();
        @(negedge clk);
        checkOutput("satCount_hold", satCount, 8'hFF);
        tick();
        clearSat = 1'b1;
        tick();
        clearSat = 1'b0;
        @(negedge clk);
        checkOutput("satCount_clear", satCount, 0);
        tick();

        lat_chk  = 1'b0;
        outReady = 1'b0;
        applyStimulus(1'b0, 3'd7, 4'b1111, 1'b1, 8'h7F);
        inValid = 1'b0;
        for (int i = 0; i < 20 && !outValid; i++) tick();
        checkOutput("clr_outValid", outValid, 1);
        clearSat = 1'b1;
        outReady = 1'b1;
        tick();
        clearSat = 1'b0;
        @(negedge clk);
        checkOutput("satCount_clear_wins", satCount, 0);
        tick();
        applyStimulus(1'b0, 3'd7, 4'b1111, 1'b1, 8'h7F);
        inValid = 1'b0;
        waitDrain();
        @(negedge clk);
        checkOutput("satCount_after_clear", satCount, 1);
        tick();

        $display("[TB] reset with items in flight");
        outReady = 1'b0;
        applyStimulus(1'b0, 3'd1, 4'b1000, 1'b0, 8'h18);
        applyStimulus(1'b1, 3'd5, 4'b1001, 1'b1, 8'hDA);
        inValid = 1'b0;
        rst = 1'b1;
        tick();
        @(negedge clk);
        checkOutput("rst_outValid", outValid, 0);
        checkOutput("rst_fpOut", fpOut, 8'h00);
        checkOutput("rst_satCount", satCount, 0);
        exp_q.delete();
        cyc_q.delete();
        tick();
        rst      = 1'b0;
        outReady = 1'b1;
        @(negedge clk);
        checkOutput("rst_inReady", inReady, 1);
        repeat (8) tick();
        @(negedge clk);
        checkOutput("rst_no_emit", outValid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
